// File: rtl/sensor_line_reader_if.sv
// Output stream bundle for the sensor line reader.
// Valid/ready handshake with an end-of-burst flag.
interface sensor_line_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/sensor_line_reader.sv
// Burst reader for the sensor line memory.
// Hides the 1-cycle RAM latency behind a 2-entry credit-gated FIFO.
module sensor_line_reader #(
  parameter  int DATA_WIDTH = 8,
  parameter  int MEM_DEEP   = 256,
  parameter  int LEN_WIDTH  = 9,
  localparam int AW         = $clog2(MEM_DEEP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [AW-1:0]         base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [AW-1:0]         mem_raddr_o,
  output logic                  mem_ren_o,
  input  logic [DATA_WIDTH-1:0] mem_dout_i,
  sensor_line_reader_if.master  m
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rd_left_q, rd_left_d;
  logic [LEN_WIDTH-1:0]  out_left_q, out_left_d;
  logic                  inflight_q;
  logic                  done_q, done_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fifo0_q, fifo0_d;
  logic [DATA_WIDTH-1:0] fifo1_q, fifo1_d;

  logic       ren;
  logic       pop;
  logic       push;
  logic       accept;
  logic       zero_cmd;
  logic [2:0] occ;
  logic [1:0] slot;

  assign pop      = (cnt_q != 2'd0) & m.ready;
  assign push     = inflight_q;
  assign accept   = (state_q == IDLE) & start_i
                  & (len_i != '0);
  assign zero_cmd = (state_q == IDLE) & start_i
                  & (len_i == '0);
  // words already owed to the FIFO once this cycle's pop retires
  assign occ      = {1'b0, cnt_q}
                  + {2'b0, inflight_q}
                  - {2'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = READ;
      READ:  if (ren && rd_left_q == LEN_WIDTH'(1))
               state_d = DRAIN;
      DRAIN: if (pop && out_left_q == LEN_WIDTH'(1))
               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ren    = (state_q == READ) & (occ < 3'd2);
    busy_o = (state_q != IDLE);
  end

  always_comb begin
    addr_d     = addr_q;
    rd_left_d  = rd_left_q;
    out_left_d = out_left_q;
    if (accept) begin
      addr_d     = base_addr_i;
      rd_left_d  = len_i;
      out_left_d = len_i;
    end else begin
      if (ren) begin
        addr_d    = (addr_q == AW'(MEM_DEEP - 1))
                  ? '0 : addr_q + AW'(1);
        rd_left_d = rd_left_q - LEN_WIDTH'(1);
      end
      if (pop && out_left_q != '0)
        out_left_d = out_left_q - LEN_WIDTH'(1);
    end
    done_d = zero_cmd
           | ((state_q == DRAIN) & pop
              & (out_left_q == LEN_WIDTH'(1)));
  end

  // head is always fifo0; a pop shifts, a push fills the next free slot
  always_comb begin
    fifo0_d = fifo0_q;
    fifo1_d = fifo1_q;
    slot    = cnt_q - {1'b0, pop};
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
    if (pop) fifo0_d = fifo1_q;
    if (push) begin
      if (slot == 2'd0) fifo0_d = mem_dout_i;
      else              fifo1_d = mem_dout_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= 2'd0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
    end else begin
      addr_q     <= addr_d;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      inflight_q <= ren;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
    end
  end

  assign done_o      = done_q;
  assign mem_raddr_o = addr_q;
  assign mem_ren_o   = ren;
  assign m.data      = fifo0_q;
  assign m.valid     = (cnt_q != 2'd0);
  assign m.last      = m.valid
                     & (out_left_q == LEN_WIDTH'(1));

endmodule

// File: tb/tb_sensor_line_reader.sv
// Bench for sensor_line_reader: random RAM contents and bursts
// checked against a queue of expected words built from the RAM.
module tb_sensor_line_reader;
  localparam int DW   = 8;
  localparam int DEEP = 256;
  localparam int LW   = 9;
  localparam int AW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr;
  logic          ren;
  logic [DW-1:0] dout;
  logic [DW-1:0] ram [DEEP];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sensor_line_reader_if #(.DATA_WIDTH(DW)) s_if ();

  sensor_line_reader #(
    .DATA_WIDTH(DW),
    .MEM_DEEP  (DEEP),
    .LEN_WIDTH (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .base_addr_i(base),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .mem_raddr_o(raddr),
    .mem_ren_o  (ren),
    .mem_dout_i (dout),
    .m          (s_if)
  );

  always @(posedge clk)
    if (ren) dout <= ram[raddr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_ren"},   ren, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_valid"}, s_if.valid, 0);
    chk({tag, "_last"},  s_if.last, 0);
    chk({tag, "_data"},  s_if.data, 0);
  endtask

  // mode: 0 ready=1, 1 ready pattern 1,0,0, 2 random ready
  task automatic burst(input int b, input int n,
                       input int mode, input bit restart,
                       input int abort_at);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] stall_data;
    int  issued    = 0;
    int  popped    = 0;
    int  cyc       = 1;
    int  done_cnt  = 0;
    int  done_cyc  = 0;
    int  last_pop  = 0;
    int  first_pop = -1;
    int  max_occ   = 0;
    int  bound;
    bit  stall     = 0;
    bit  done_seen = 0;
    for (int i = 0; i < n; i++)
      exp_q.push_back(ram[(b + i) % DEEP]);
    bound = 4 * n + 40;
    @(negedge clk);
    start = 1'b1;
    base  = AW'(b);
    len   = LW'(n);
    @(negedge clk);
    start = 1'b0;
    forever begin
      case (mode)
        0:       s_if.ready = 1'b1;
        1:       s_if.ready = ((cyc - 1) % 3 == 0);
        default: s_if.ready = 1'($urandom_range(0, 1));
      endcase
      start = restart && (cyc == 3);
      if (start) begin
        base = AW'($urandom);
        len  = LW'($urandom_range(1, 50));
      end
      #1;
      if (issued - popped > max_occ)
        max_occ = issued - popped;
      if (mode == 0 && n > 0 && cyc <= 3) begin
        if (cyc == 1) chk("lat_ren", ren, 1);
        chk("lat_valid", s_if.valid, (cyc == 3));
      end
      if (stall) begin
        chk("stall_valid", s_if.valid, 1);
        chk("stall_data", s_if.data, stall_data);
      end
      if (ren) begin
        chk("raddr", raddr, (b + issued) % DEEP);
        issued++;
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_seen = 1;
        chk("done_timing", cyc, last_pop + 1);
        chk("done_words", popped, n);
      end
      chk("busy", busy, (n != 0 && !done_seen));
      if (s_if.valid && s_if.ready) begin
        chk("in_range", (popped < n), 1);
        if (popped < n) begin
          chk("data", s_if.data, exp_q[popped]);
          chk("last", s_if.last, (popped == n - 1));
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        popped++;
      end
      stall      = s_if.valid && !s_if.ready;
      stall_data = s_if.data;
      if (abort_at != 0 && popped == abort_at) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("abort");
        s_if.ready = 1'b0;
        return;
      end
      if (done_seen && cyc >= done_cyc + 3) break;
      if (cyc >= bound) begin
        chk("timeout_done", done_seen, 1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("words", popped, n);
    chk("done_once", done_cnt, 1);
    chk("reads", issued, n);
    chk("occupancy", (max_occ <= 2), 1);
    if (mode == 0 && n > 0)
      chk("no_bubble", last_pop - first_pop, n - 1);
    s_if.ready = 1'b0;
  endtask

  initial begin
    start      = 1'b0;
    base       = '0;
    len        = '0;
    s_if.ready = 1'b0;
    for (int i = 0; i < DEEP; i++) ram[i] = DW'($urandom);
    #3 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    burst(10, 4, 0, 0, 0);
    burst(254, 4, 0, 0, 0);
    burst($urandom_range(0, 255), 8, 1, 0, 0);
    burst(77, 0, 0, 0, 0);
    burst($urandom_range(0, 255), 6, 2, 1, 0);
    burst($urandom_range(0, 255), 16, 0, 0, 3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    burst(0, 2, 0, 0, 0);
    burst($urandom_range(0, 255), 300, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      burst($urandom_range(0, 255), $urandom_range(1, 20),
            $urandom_range(0, 2), 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
